// File: rtl/seq_detector_param.sv
// Serial pattern detector: compares the last LEN accepted bits against a loadable pattern.
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise match_cnt reads 0.
module seq_detector_param #(
   parameter int unsigned         LEN      = 3,
   parameter logic [LEN-1:0]      PAT_INIT = LEN'(3'b101),
   parameter int unsigned         CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x,
   input  logic             in_valid,
   input  logic             overlap,
   input  logic             pat_load,
   input  logic [LEN-1:0]   pat_in,
   input  logic             cnt_clr,
   output logic             match,
   output logic             armed,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int unsigned       FILL_W    = $clog2(LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

   typedef enum logic {
      FILL = 1'b0,
      HUNT = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [LEN-1:0]    hist_q, hist_d;
   logic [LEN-1:0]    pat_q, pat_d;
   logic              match_q, match_d;
   logic [LEN-1:0]    shift_c;
   logic [FILL_W-1:0] fill_inc_c;

   // State, history, fill count, pattern and match pulse registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FILL;
         fill_q  <= '0;
         hist_q  <= '0;
         pat_q   <= PAT_INIT;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         hist_q  <= hist_d;
         pat_q   <= pat_d;
         match_q <= match_d;
      end
   end

   // Next-state: pattern load restarts; accepted bits shift in and may complete a match
   always_comb begin
      state_d    = state_q;
      fill_d     = fill_q;
      hist_d     = hist_q;
      pat_d      = pat_q;
      match_d    = 1'b0;
      shift_c    = {hist_q[LEN-2:0], x};
      fill_inc_c = fill_q;

      case (state_q)
         FILL:    fill_inc_c = fill_q + FILL_W'(1);
         HUNT:    fill_inc_c = FILL_FULL;
         default: fill_inc_c = fill_q;
      endcase

      if (pat_load) begin
         pat_d   = pat_in;
         hist_d  = '0;
         fill_d  = '0;
         state_d = FILL;
      end else if (in_valid) begin
         hist_d  = shift_c;
         fill_d  = fill_inc_c;
         state_d = (fill_inc_c == FILL_FULL) ? HUNT : FILL;
         if ((fill_inc_c == FILL_FULL) && (shift_c == pat_q)) begin
            match_d = 1'b1;
            // Non-overlapping: keep history but demand LEN fresh bits
            if (!overlap) begin
               fill_d  = '0;
               state_d = FILL;
            end
         end
      end
   end

   assign match = match_q;
   assign armed = (state_q == HUNT);

`ifdef SEQDET_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating counter; clear beats a same-cycle increment
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (match_d && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match_cnt = cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random stimulus against a bit-queue model.
module tb_seq_detector_param;

   localparam int LEN = 3;
`ifdef SEQDET_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       x, in_valid, overlap, pat_load, cnt_clr;
   logic [2:0] pat_in;
   logic       match_a, armed_a, match_b, armed_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: bits accepted since the last restart, oldest first
   bit         mbits[$];
   logic [2:0] mpat;
   logic       exp_match, exp_armed;
   logic [7:0] exp_cnt_a;
   logic [1:0] exp_cnt_b;

   seq_detector_param #(.LEN(3), .PAT_INIT(3'b101), .CNT_W(8)) dut_a (
      .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .overlap(overlap),
      .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
      .match(match_a), .armed(armed_a), .match_cnt(cnt_a));

   seq_detector_param #(.LEN(3), .PAT_INIT(3'b101), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .overlap(overlap),
      .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
      .match(match_b), .armed(armed_b), .match_cnt(cnt_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      mbits.delete();
      mpat      = 3'b101;
      exp_match = 1'b0;
      exp_armed = 1'b0;
      exp_cnt_a = '0;
      exp_cnt_b = '0;
   endtask

   task automatic model_update();
      logic hit;
      hit = 1'b0;
      if (pat_load) begin
         mpat = pat_in;
         mbits.delete();
      end else if (in_valid) begin
         mbits.push_back(x);
         if (mbits.size() > LEN) void'(mbits.pop_front());
         if (mbits.size() == LEN) begin
            hit = 1'b1;
            for (int i = 0; i < LEN; i++)
               if (mbits[i] != mpat[LEN-1-i]) hit = 1'b0;
            if (hit && !overlap) mbits.delete();
         end
      end
      exp_match = hit;
      exp_armed = (mbits.size() == LEN);
      if (CNT_ON) begin
         if (cnt_clr) begin
            exp_cnt_a = '0;
            exp_cnt_b = '0;
         end else if (hit) begin
            if (exp_cnt_a != 8'hFF) exp_cnt_a = exp_cnt_a + 8'd1;
            if (exp_cnt_b != 2'd3)  exp_cnt_b = exp_cnt_b + 2'd1;
         end
      end
   endtask

   task automatic set_idle();
      x = 1'b0; in_valid = 1'b0; overlap = 1'b0; pat_load = 1'b0; pat_in = 3'b000; cnt_clr = 1'b0;
   endtask

   // Drive one cycle of inputs, advance the model at the edge, return 1ns after it
   task automatic step(input logic bx, input logic bv, input logic bo, input logic bl,
                       input logic [2:0] bp, input logic bc);
      x = bx; in_valid = bv; overlap = bo; pat_load = bl; pat_in = bp; cnt_clr = bc;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      set_idle();
      reset = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      set_idle();
      reset = 1'b0;
      model_reset();
      #2;
      n_checks++;
      if ({match_a, armed_a, cnt_a, match_b, armed_b, cnt_b} !== 14'd0)
         $display("FAIL reset_assert: got %b %b %0d %0d want 0 0 0 0", match_a, armed_a, cnt_a, cnt_b);
      else n_pass++;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({match_a, armed_a, cnt_a, match_b, armed_b, cnt_b} !== 14'd0)
         $display("FAIL reset_release: got %b %b %0d %0d want 0 0 0 0", match_a, armed_a, cnt_a, cnt_b);
      else n_pass++;
   endtask

   task automatic test_stream(input logic ovl, input int want_pulses, input string name);
      logic [4:0] s;
      int pulses;
      s = 5'b10101;
      pulses = 0;
      do_reset();
      for (int i = 4; i >= 0; i--) begin
         step(s[i], 1'b1, ovl, 1'b0, 3'b000, 1'b0);
         pulses += int'(match_a);
         n_checks++;
         if ({match_a, armed_a, cnt_a, match_b, armed_b, cnt_b} !==
             {exp_match, exp_armed, exp_cnt_a, exp_match, exp_armed, exp_cnt_b})
            $display("FAIL %s bit%0d: got m=%b a=%b c=%0d/%0d want m=%b a=%b c=%0d/%0d", name, 5 - i,
                     match_a, armed_a, cnt_a, cnt_b, exp_match, exp_armed, exp_cnt_a, exp_cnt_b);
         else n_pass++;
      end
      n_checks++;
      if (pulses !== want_pulses) $display("FAIL %s pulses: got %0d want %0d", name, pulses, want_pulses);
      else n_pass++;
   endtask

   task automatic test_pat_load();
      logic [6:0] bx, bl;
      bx = 7'b1011110;
      bl = 7'b0010000;
      do_reset();
      for (int i = 6; i >= 0; i--) begin
         step(bx[i], 1'b1, 1'b1, bl[i], 3'b110, 1'b0);
         n_checks++;
         if ({match_a, armed_a, cnt_a, match_b, armed_b, cnt_b} !==
             {exp_match, exp_armed, exp_cnt_a, exp_match, exp_armed, exp_cnt_b})
            $display("FAIL pat_load cyc%0d: got m=%b a=%b c=%0d want m=%b a=%b c=%0d", 7 - i,
                     match_a, armed_a, cnt_a, exp_match, exp_armed, exp_cnt_a);
         else n_pass++;
      end
      n_checks++;
      if (match_a !== 1'b1) $display("FAIL pat_load final: got match=%b want 1", match_a);
      else n_pass++;
   endtask

   task automatic test_gap();
      do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 3'b000, 1'b0);
         n_checks++;
         if ({match_a, armed_a, match_b, armed_b} !== 4'b0000)
            $display("FAIL gap cyc%0d: got m=%b a=%b want 0 0", i, match_a, armed_a);
         else n_pass++;
      end
      step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      n_checks++;
      if ({match_a, armed_a, match_b, armed_b} !== 4'b1111)
         $display("FAIL gap completion: got m=%b a=%b want 1 1", match_a, armed_a);
      else n_pass++;
   endtask

   task automatic test_saturation();
      logic [14:0] s;
      s = 15'b101010101010101;
      do_reset();
      for (int i = 14; i >= 0; i--) begin
         step(s[i], 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
         n_checks++;
         if ({match_a, cnt_a, match_b, cnt_b} !== {exp_match, exp_cnt_a, exp_match, exp_cnt_b})
            $display("FAIL saturate bit%0d: got m=%b c=%0d/%0d want m=%b c=%0d/%0d", 15 - i,
                     match_a, cnt_a, cnt_b, exp_match, exp_cnt_a, exp_cnt_b);
         else n_pass++;
      end
      n_checks++;
      if (cnt_b !== (CNT_ON ? 2'd3 : 2'd0)) $display("FAIL saturate final: got %0d want %0d", cnt_b, CNT_ON ? 3 : 0);
      else n_pass++;
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
      n_checks++;
      if ({match_a, cnt_a, match_b, cnt_b} !== {1'b1, 8'd0, 1'b1, 2'd0})
         $display("FAIL clr_with_match: got m=%b c=%0d/%0d want m=1 c=0/0", match_a, cnt_a, cnt_b);
      else n_pass++;
   endtask

   task automatic test_reset_midstream();
      do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      n_checks++;
      if ({match_a, armed_a, match_b, armed_b} !== 4'b0000)
         $display("FAIL midreset first_bit: got m=%b a=%b want 0 0", match_a, armed_a);
      else n_pass++;
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      n_checks++;
      if ({match_a, armed_a, match_b, armed_b} !== 4'b1111)
         $display("FAIL midreset refill: got m=%b a=%b want 1 1", match_a, armed_a);
      else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 39) == 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 29) == 0));
         n_checks++;
         if ({match_a, armed_a, cnt_a, match_b, armed_b, cnt_b} !==
             {exp_match, exp_armed, exp_cnt_a, exp_match, exp_armed, exp_cnt_b})
            $display("FAIL random cyc%0d: got m=%b a=%b c=%0d/%0d want m=%b a=%b c=%0d/%0d", i,
                     match_a, armed_a, cnt_a, cnt_b, exp_match, exp_armed, exp_cnt_a, exp_cnt_b);
         else n_pass++;
      end
   endtask

   initial begin
      set_idle();
      reset = 1'b0;
      model_reset();
      test_reset();
      test_stream(1'b1, 2, "overlap");
      test_stream(1'b0, 1, "nonoverlap");
      test_pat_load();
      test_gap();
      test_saturation();
      test_reset_midstream();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
